// File: rtl/smpc_pad_port_seq.sv
// rtl/smpc_pad_port_seq.sv - SMPC controller-port read sequencer
// Probes TH/TR, classifies the peripheral from the MD ID nibble and streams ID and payload bytes.
module smpc_pad_port_seq #(
  parameter int SETTLE    = 4,
  parameter int TIMEOUT   = 255,
  parameter int MAX_BYTES = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CE,
  input  logic       START,
  output logic [6:0] PDRO,
  output logic [6:0] DDR,
  input  logic [6:0] PDRI,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] ID,
  output logic [4:0] LEN,
  output logic       DATA_WE,
  output logic [3:0] DATA_ADDR,
  output logic [7:0] DATA
);
  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE_HI, S_PROBE_LO, S_DIG_00, S_DIG_10, S_DIG_WR, S_HS_WAIT, S_FINISH
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    thtr_q;
  logic          busy_q, done_q, err_q, we_q;
  logic [7:0]    id_q, data_q;
  logic [4:0]    len_q;
  logic [3:0]    addr_q, a_q, b_q, n00_q, hi_q, bytes_q;
  logic [1:0]    stage_q;

  logic [3:0] nib_d, md_id_d, count_d;
  logic [7:0] hs_id_d;
  logic [4:0] len_inc_d;
  logic       settled_d, timeout_d, tl_match_d, unused_d;

  assign nib_d      = PDRI[3:0];
  assign settled_d  = (cnt_q == CW'(SETTLE - 1));
  assign timeout_d  = (cnt_q == CW'(TIMEOUT - 1));
  assign tl_match_d = (PDRI[4] == thtr_q[0]);
  assign md_id_d    = {a_q[3] | a_q[2], a_q[1] | a_q[0], nib_d[3] | nib_d[2], nib_d[1] | nib_d[0]};
  assign hs_id_d    = {hi_q, nib_d};
  assign len_inc_d  = len_q + 5'd1;
  assign unused_d   = ^PDRI[6:5];

  // A 0xFF handshake ID is a mouse, which always returns three bytes.
  always_comb begin
    count_d = nib_d;
    if (hs_id_d == 8'hFF)              count_d = 4'd3;
    else if (int'(nib_d) > MAX_BYTES)  count_d = 4'(MAX_BYTES);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      thtr_q  <= 2'b11;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      id_q    <= 8'hFF;
      data_q  <= 8'h00;
      len_q   <= 5'd0;
      addr_q  <= 4'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      n00_q   <= 4'd0;
      hi_q    <= 4'd0;
      bytes_q <= 4'd0;
      stage_q <= 2'd0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      if (CE) begin
        case (state_q)
          S_IDLE: if (START) begin
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            len_q   <= 5'd0;
            id_q    <= 8'hFF;
            cnt_q   <= '0;
            state_q <= S_PROBE_HI;
          end
          S_PROBE_HI: if (settled_d) begin
            a_q     <= nib_d;
            thtr_q  <= 2'b01;
            cnt_q   <= '0;
            state_q <= S_PROBE_LO;
          end else cnt_q <= cnt_q + 1'b1;
          S_PROBE_LO: if (settled_d) begin
            b_q   <= nib_d;
            cnt_q <= '0;
            case (md_id_d)
              4'hB: begin
                thtr_q  <= 2'b00;
                state_q <= S_DIG_00;
              end
              4'h3, 4'h5: begin
                thtr_q  <= 2'b00;
                stage_q <= 2'd0;
                state_q <= S_HS_WAIT;
              end
              default: begin
                id_q    <= (md_id_d == 4'hA) ? 8'h0A : 8'hFF;
                thtr_q  <= 2'b11;
                state_q <= S_FINISH;
              end
            endcase
          end else cnt_q <= cnt_q + 1'b1;
          S_DIG_00: if (settled_d) begin
            n00_q   <= nib_d;
            thtr_q  <= 2'b10;
            cnt_q   <= '0;
            state_q <= S_DIG_10;
          end else cnt_q <= cnt_q + 1'b1;
          S_DIG_10: if (settled_d) begin
            we_q    <= 1'b1;
            data_q  <= {b_q, nib_d};
            addr_q  <= 4'd0;
            len_q   <= 5'd1;
            state_q <= S_DIG_WR;
          end else cnt_q <= cnt_q + 1'b1;
          S_DIG_WR: begin
            we_q    <= 1'b1;
            data_q  <= {n00_q, a_q};
            addr_q  <= 4'd1;
            len_q   <= 5'd2;
            id_q    <= 8'h02;
            thtr_q  <= 2'b11;
            cnt_q   <= '0;
            state_q <= S_FINISH;
          end
          // stage: 0 ID high, 1 ID low, 2 payload high, 3 payload low
          S_HS_WAIT: if (tl_match_d) begin
            cnt_q     <= '0;
            thtr_q[0] <= ~thtr_q[0];
            case (stage_q)
              2'd0: begin
                hi_q    <= nib_d;
                stage_q <= 2'd1;
              end
              2'd1: begin
                id_q    <= (hs_id_d == 8'hFF) ? 8'hE3 : hs_id_d;
                bytes_q <= count_d;
                stage_q <= 2'd2;
                if (count_d == 4'd0) begin
                  thtr_q  <= 2'b11;
                  state_q <= S_FINISH;
                end
              end
              2'd2: begin
                hi_q    <= nib_d;
                stage_q <= 2'd3;
              end
              default: begin
                we_q    <= 1'b1;
                data_q  <= {hi_q, nib_d};
                addr_q  <= len_q[3:0];
                len_q   <= len_inc_d;
                stage_q <= 2'd2;
                if (len_inc_d == {1'b0, bytes_q}) begin
                  thtr_q  <= 2'b11;
                  state_q <= S_FINISH;
                end
              end
            endcase
          end else if (timeout_d) begin
            err_q   <= 1'b1;
            id_q    <= 8'hFF;
            thtr_q  <= 2'b11;
            cnt_q   <= '0;
            state_q <= S_FINISH;
          end else cnt_q <= cnt_q + 1'b1;
          S_FINISH: if (settled_d) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else cnt_q <= cnt_q + 1'b1;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign PDRO      = {thtr_q, 5'h1F};
  assign DDR       = 7'h60;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign ID        = id_q;
  assign LEN       = len_q;
  assign DATA_WE   = we_q;
  assign DATA_ADDR = addr_q;
  assign DATA      = data_q;
endmodule

// File: tb/tb_smpc_pad_port_seq.sv
// tb/tb_smpc_pad_port_seq.sv - directed bench for smpc_pad_port_seq
// Peripheral models: digital pad, 3-wire handshake device (optionally frozen TL), fixed nibble.
module tb_smpc_pad_port_seq;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 255;

  logic       CLK = 1'b0, RST_N = 1'b0, CE = 1'b0, START = 1'b0;
  logic [6:0] PDRI = 7'h7F;
  logic [6:0] PDRO, DDR;
  logic       BUSY, DONE, ERR, DATA_WE;
  logic [7:0] ID, DATA;
  logic [4:0] LEN;
  logic [3:0] DATA_ADDR;

  smpc_pad_port_seq #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .MAX_BYTES(15)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .START(START), .PDRO(PDRO), .DDR(DDR), .PDRI(PDRI),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ID(ID), .LEN(LEN), .DATA_WE(DATA_WE),
    .DATA_ADDR(DATA_ADDR), .DATA(DATA)
  );

  always #5 CLK = ~CLK;

  int ce_ticks = 0;
  always @(posedge CLK) if (CE) ce_ticks <= ce_ticks + 1;

  typedef enum int {M_DIG, M_HS, M_FIX} mode_t;
  mode_t      mode;
  logic [15:0] joy;
  logic [3:0] hs_a, hs_b, fix_nib;
  logic [3:0] nibs [0:15];
  int         nn;
  bit         freeze;

  int         tog = 0, freeze_tick = 0, freeze_cnt = 0;
  logic       last_tr = 1'b1, tl = 1'b1;
  logic [3:0] nib = 4'hF;

  // Peripheral models react on the falling edge; CE runs at half the clock rate.
  always @(negedge CLK) begin
    CE = ~CE;
    tl = 1'b1;
    case (mode)
      M_DIG: case (PDRO[6:5])
        2'b11:   nib = {joy[3], 3'b100};
        2'b01:   nib = joy[15:12];
        2'b00:   nib = joy[7:4];
        default: nib = joy[11:8];
      endcase
      M_HS: if (PDRO[6:5] == 2'b11) begin
        tog = 0; last_tr = 1'b1; nib = hs_a; tl = 1'b1;
      end else begin
        if (PDRO[5] != last_tr) begin
          tog++;
          if (freeze && tog == 3) begin freeze_tick = ce_ticks; freeze_cnt++; end
        end
        last_tr = PDRO[5];
        nib = (tog == 0) ? hs_b : ((tog <= nn) ? nibs[tog-1] : 4'h0);
        tl = (freeze && tog >= 3) ? PDRI[4] : PDRO[5];
      end
      default: nib = fix_nib;
    endcase
    PDRI = {2'b11, tl, nib};
  end

  int         we_cnt = 0, done_cnt = 0, done_tick = 0;
  logic [7:0] cap_d [0:63];
  logic [3:0] cap_a [0:63];
  always @(negedge CLK) begin
    if (DATA_WE) begin
      cap_d[we_cnt % 64] = DATA;
      cap_a[we_cnt % 64] = DATA_ADDR;
      we_cnt++;
    end
    if (DONE) begin
      done_cnt++;
      done_tick = ce_ticks;
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge CLK); while (CE !== 1'b1);
  endtask

  task automatic do_start();
    wait_tick(); #1 START = 1'b1;
    wait_tick(); #1 START = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int k = 0;
    while (done_cnt == base && k < 4000) begin @(posedge CLK); #7; k++; end
    repeat (10) @(posedge CLK);
    #7;
  endtask

  task automatic load_nibs(input logic [63:0] v, input int n);
    for (int i = 0; i < 16; i++) nibs[i] = v[63-4*i -: 4];
    nn = n;
  endtask

  task automatic chk_byte(input string tag, input int idx, input logic [7:0] d, input logic [3:0] a);
    chk({tag, " data"}, cap_d[idx % 64], d);
    chk({tag, " addr"}, cap_a[idx % 64], a);
  endtask

  task automatic run_analog(input string tag);
    int wb, db;
    mode = M_HS; hs_a = 4'h1; hs_b = 4'h1; freeze = 0;
    load_nibs(64'h15FF_FF80_8000_0000, 12);
    wb = we_cnt; db = done_cnt;
    do_start();
    wait_done(db);
    chk({tag, " done_once"}, done_cnt - db, 1);
    chk({tag, " id"}, ID, 8'h15);
    chk({tag, " len"}, LEN, 5);
    chk({tag, " err"}, ERR, 0);
    chk({tag, " we_cnt"}, we_cnt - wb, 5);
    chk_byte({tag, " b0"}, wb,     8'hFF, 4'd0);
    chk_byte({tag, " b1"}, wb + 1, 8'hFF, 4'd1);
    chk_byte({tag, " b2"}, wb + 2, 8'h80, 4'd2);
    chk_byte({tag, " b3"}, wb + 3, 8'h80, 4'd3);
    chk_byte({tag, " b4"}, wb + 4, 8'h00, 4'd4);
    chk({tag, " thtr"}, PDRO[6:5], 2'b11);
    chk({tag, " busy"}, BUSY, 0);
  endtask

  initial begin
    int wb, db, k;
    mode = M_FIX; fix_nib = 4'hF; joy = 16'h0; hs_a = 4'h0; hs_b = 4'h0; freeze = 0;
    load_nibs(64'h0, 0);
    repeat (3) @(posedge CLK);
    #2;
    chk("rst pdro", PDRO, 7'h7F);
    chk("rst ddr", DDR, 7'h60);
    chk("rst flags", {BUSY, DONE, ERR, DATA_WE}, 4'b0000);
    chk("rst id", ID, 8'hFF);
    chk("rst len_addr_data", {LEN, DATA_ADDR, DATA}, 17'h0);
    RST_N = 1'b1;
    repeat (4) @(posedge CLK);

    // digital pad
    mode = M_DIG; joy = 16'hEF7F;
    wb = we_cnt; db = done_cnt;
    do_start();
    #7 chk("dig busy_on_start", BUSY, 1);
    wait_done(db);
    chk("dig done_once", done_cnt - db, 1);
    chk("dig id", ID, 8'h02);
    chk("dig len", LEN, 2);
    chk("dig err", ERR, 0);
    chk("dig we_cnt", we_cnt - wb, 2);
    chk_byte("dig b0", wb,     8'hEF, 4'd0);
    chk_byte("dig b1", wb + 1, 8'h7C, 4'd1);

    run_analog("analog");

    // mouse
    mode = M_HS; hs_a = 4'h0; hs_b = 4'hB; freeze = 0;
    load_nibs(64'hFF00_1234_0000_0000, 8);
    wb = we_cnt; db = done_cnt;
    do_start();
    wait_done(db);
    chk("mouse done_once", done_cnt - db, 1);
    chk("mouse id", ID, 8'hE3);
    chk("mouse len", LEN, 3);
    chk("mouse we_cnt", we_cnt - wb, 3);
    chk_byte("mouse b0", wb,     8'h00, 4'd0);
    chk_byte("mouse b1", wb + 1, 8'h12, 4'd1);
    chk_byte("mouse b2", wb + 2, 8'h34, 4'd2);

    // Stunner and empty port
    mode = M_FIX; fix_nib = 4'hC;
    wb = we_cnt; db = done_cnt;
    do_start();
    wait_done(db);
    chk("stun done_once", done_cnt - db, 1);
    chk("stun id", ID, 8'h0A);
    chk("stun len", LEN, 0);
    chk("stun we_cnt", we_cnt - wb, 0);
    fix_nib = 4'hF;
    db = done_cnt;
    do_start();
    wait_done(db);
    chk("empty done_once", done_cnt - db, 1);
    chk("empty id", ID, 8'hFF);
    chk("empty len_err", {LEN, ERR}, 6'h0);

    // handshake timeout after the ID byte
    mode = M_HS; hs_a = 4'h1; hs_b = 4'h1; freeze = 1;
    load_nibs(64'h15FF_FF80_8000_0000, 12);
    wb = we_cnt; db = done_cnt; k = freeze_cnt;
    do_start();
    for (int i = 0; i < 400 && freeze_cnt == k; i++) begin @(posedge CLK); #7; end
    chk("tmo froze", freeze_cnt - k, 1);
    repeat (40) @(posedge CLK);
    #7 chk("tmo busy_mid", BUSY, 1);
    chk("tmo ddr_mid", DDR, 7'h60);
    do_start();
    #7 chk("tmo busy_after_restart", BUSY, 1);
    wait_done(db);
    chk("tmo done_once", done_cnt - db, 1);
    chk("tmo done_latency", done_tick - freeze_tick, TIMEOUT + SETTLE);
    chk("tmo err", ERR, 1);
    chk("tmo id", ID, 8'hFF);
    chk("tmo len", LEN, 0);
    chk("tmo we_cnt", we_cnt - wb, 0);
    chk("tmo busy_end", BUSY, 0);
    freeze = 0;

    // reset mid-payload
    load_nibs(64'h15FF_FF80_8000_0000, 12);
    wb = we_cnt;
    do_start();
    for (int i = 0; i < 400 && we_cnt == wb; i++) begin @(posedge CLK); #7; end
    chk("rst_mid we_seen", we_cnt != wb, 1);
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_mid pdro", PDRO, 7'h7F);
    chk("rst_mid busy", BUSY, 0);
    chk("rst_mid id_len", {ID, LEN}, {8'hFF, 5'd0});
    #10 RST_N = 1'b1;
    repeat (4) @(posedge CLK);
    run_analog("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
